muldiv_unit: RTL and testbench

- Iterative 16-bit unsigned multiply/divide unit that sits directly downstream of the register file read ports and directly upstream of its write port.
- Operands come from the register file A/B output buses.
- The unit drives the register file write-select and write-data inputs for two consecutive cycles:
  - MUL writes the product low half, then the high half.
  - DIV writes the quotient, then the remainder.
- It is multi-cycle: the sequencer stalls on `busy` while the operation runs.

---
 rtl/muldiv_unit.sv | 128 ++++++++++++
 tb/tb_muldiv_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 16-bit unsigned multiply/divide unit.
// Writes lo/quotient and then hi/remainder back to the register file on two consecutive cycles.
module muldiv_unit #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [SEL_W-1:0] dst_lo,
    input  logic [SEL_W-1:0] dst_hi,
    output logic             busy,
    output logic             done,
    output logic             wb_we,
    output logic [SEL_W-1:0] wb_dst,
    output logic [WIDTH-1:0] wb_val,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_t;

    state_t           state;
    logic             op_div;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [SEL_W-1:0] dlo;
    logic [SEL_W-1:0] dhi;
    logic [4:0]       cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    // acc_hi/acc_lo hold {product hi, multiplier} for MULU and {remainder, dividend/quotient} for DIVU
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        nxt_hi  = sum[WIDTH:1];
        nxt_lo  = {sum[0], acc_lo[WIDTH-1:1]};
        if (op_div) begin
            if (shifted >= {1'b0, opnd}) begin
                nxt_hi = WIDTH'(shifted - {1'b0, opnd});
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state       <= IDLE;
            op_div      <= 1'b0;
            opnd        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            dlo         <= '0;
            dhi         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wb_we       <= 1'b0;
            wb_dst      <= '0;
            wb_val      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_div      <= op;
                        dlo         <= dst_lo;
                        dhi         <= dst_hi;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        cnt         <= 5'(WIDTH);
                        acc_hi      <= '0;
                        if (op && (b_in == '0)) begin
                            div_by_zero <= 1'b1;
                            acc_hi      <= a_in;
                            wb_we       <= 1'b1;
                            wb_dst      <= dst_lo;
                            wb_val      <= '1;
                            state       <= WB_LO;
                        end else begin
                            opnd   <= op ? b_in : a_in;
                            acc_lo <= op ? a_in : b_in;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt - 5'd1;
                    // Final step result goes straight into the registered write port
                    if (cnt == 5'd1) begin
                        wb_we  <= 1'b1;
                        wb_dst <= dlo;
                        wb_val <= nxt_lo;
                        state  <= WB_LO;
                    end
                end
                WB_LO: begin
                    wb_dst <= dhi;
                    wb_val <= acc_hi;
                    done   <= 1'b1;
                    state  <= WB_HI;
                end
                WB_HI: begin
                    wb_we  <= 1'b0;
                    wb_dst <= '0;
                    wb_val <= '0;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected write-back cycles are queued at issue
// and checked by a negedge monitor along with the zero-select rule on idle cycles.
module tb_muldiv_unit;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic [3:0]  dst_lo = '0;
    logic [3:0]  dst_hi = '0;
    logic        busy, done, wb_we, div_by_zero;
    logic [3:0]  wb_dst;
    logic [15:0] wb_val;

    muldiv_unit #(.WIDTH(16), .SEL_W(4)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in), .dst_lo(dst_lo), .dst_hi(dst_hi),
        .busy(busy), .done(done), .wb_we(wb_we), .wb_dst(wb_dst),
        .wb_val(wb_val), .div_by_zero(div_by_zero)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        int          cyc;
        logic [3:0]  dst;
        logic [15:0] val;
        logic        dn;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge cpu_clk) cyc <= cyc + 1;

    always @(negedge cpu_clk) begin
        if (wb_we) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_write cyc=%0d dst=%0d val=%h required no write", cyc, wb_dst, wb_val);
            end else begin
                exp_t e;
                e = sb.pop_front();
                vectors++;
                assert (wb_dst === e.dst && wb_val === e.val && done === e.dn && cyc === e.cyc)
                else begin
                    miscompares++;
                    $error("FAIL write cyc=%0d dst=%0d val=%h done=%b required cyc=%0d dst=%0d val=%h done=%b",
                           cyc, wb_dst, wb_val, done, e.cyc, e.dst, e.val, e.dn);
                end
            end
        end else begin
            vectors++;
            assert (wb_dst === 4'd0 && wb_val === 16'd0 && done === 1'b0)
            else begin
                miscompares++;
                $error("FAIL idle_port cyc=%0d dst=%0d val=%h done=%b required 0/0/0", cyc, wb_dst, wb_val, done);
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] req);
        vectors++;
        assert (obs === req)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    // Drive one request in the current cycle and queue its two writes.
    task automatic issue(input logic o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] dl, input logic [3:0] dh);
        logic [31:0] p;
        logic [15:0] lo, hi;
        int lat;
        p   = {16'd0, a} * {16'd0, b};
        lat = 17;
        if (!o) begin
            lo = p[15:0];
            hi = p[31:16];
        end else if (b == 16'd0) begin
            lo  = 16'hFFFF;
            hi  = a;
            lat = 1;
        end else begin
            lo = a / b;
            hi = a % b;
        end
        sb.push_back('{cyc + lat, dl, lo, 1'b0});
        sb.push_back('{cyc + lat + 1, dh, hi, 1'b1});
        op = o; a_in = a; b_in = b; dst_lo = dl; dst_hi = dh; start = 1'b1;
        @(posedge cpu_clk); #1;
        start = 1'b0;
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
    endtask

    // Leaves the bench in the WB_HI cycle (done high) or flags a timeout.
    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge cpu_clk); #1;
            seen = done;
        end
        check({tag, "_done_timeout"}, {15'd0, seen}, 16'd1);
    endtask

    initial begin
        #3;
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_we", {15'd0, wb_we}, 16'd0);
        check("rst_dbz", {15'd0, div_by_zero}, 16'd0);
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;
        @(posedge cpu_clk); #1;

        issue(1'b0, 16'h1234, 16'h0100, 4'd1, 4'd2);
        check("mul_busy_c1", {15'd0, busy}, 16'd1);
        wait_done("mul1");
        @(posedge cpu_clk); #1;
        check("mul1_busy_after", {15'd0, busy}, 16'd0);

        issue(1'b0, 16'hFFFF, 16'hFFFF, 4'd5, 4'd6);
        wait_done("mul_max");
        check("mul_max_dbz", {15'd0, div_by_zero}, 16'd0);
        @(posedge cpu_clk); #1;

        issue(1'b1, 16'd1000, 16'd7, 4'd3, 4'd4);
        wait_done("div");
        @(posedge cpu_clk); #1;

        issue(1'b1, 16'h00AB, 16'h0000, 4'd7, 4'd8);
        check("dbz_set", {15'd0, div_by_zero}, 16'd1);
        wait_done("dbz");
        @(posedge cpu_clk); #1;
        check("dbz_sticky", {15'd0, div_by_zero}, 16'd1);

        issue(1'b0, 16'h00FF, 16'h0101, 4'd10, 4'd11);
        check("dbz_cleared", {15'd0, div_by_zero}, 16'd0);
        repeat (3) begin @(posedge cpu_clk); #1; end
        op = 1'b1; a_in = 16'h0055; b_in = 16'h0003; dst_lo = 4'd12; dst_hi = 4'd13; start = 1'b1;
        @(posedge cpu_clk); #1;
        start = 1'b0;
        wait_done("ignored_start");
        @(posedge cpu_clk); #1;

        issue(1'b1, 16'hFFFF, 16'h0010, 4'd9, 4'd9);
        wait_done("same_dst");
        @(posedge cpu_clk); #1;

        issue(1'b0, 16'h1111, 16'h0003, 4'd14, 4'd15);
        repeat (7) begin @(posedge cpu_clk); #1; end
        cpu_rst = 1'b1;
        #1;
        check("midrst_busy", {15'd0, busy}, 16'd0);
        check("midrst_dst", {12'd0, wb_dst}, 16'd0);
        sb.delete();
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;
        repeat (25) begin @(posedge cpu_clk); #1; end

        issue(1'b0, 16'h0ABC, 16'h0DEF, 4'd1, 4'd2);
        wait_done("post_rst");
        @(posedge cpu_clk); #1;
        check("sb_drained", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
